posit_decode_pipe: RTL and testbench

Pipelined posit decoder: accepts packed posit words over a valid/ready stream and produces the denormalized fields sign, scale, fraction, zero and NaR. It is the inverse of the normalize/round/pack stage and sits at the input of every posit arithmetic unit, feeding the arithmetic core. Three register stages, full throughput of one word per cycle, lossless backpressure.

---
 rtl/posit_decode_pipe.sv | 167 ++++++++++++++++
 tb/tb_posit_decode_pipe.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_decode_pipe.sv
// Three-stage pipelined posit decoder: packed posit word in, sign / scale / fraction
// plus zero and NaR flags out, over valid/ready handshakes with lossless backpressure.
module posit_decode_pipe #(
    parameter int POSIT_WIDTH    = 32,
    parameter int POSIT_ES       = 2,
    parameter int SCALE_WIDTH    = $clog2(POSIT_WIDTH) + POSIT_ES + 1,
    parameter int FRACTION_WIDTH = POSIT_WIDTH - POSIT_ES - 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [POSIT_WIDTH-1:0]    posit_word_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sign_o,
    output logic [SCALE_WIDTH-1:0]    scale_o,
    output logic [FRACTION_WIDTH-1:0] fraction_o,
    output logic                      zero_o,
    output logic                      NaR_o
);

    localparam int N  = POSIT_WIDTH;
    localparam int CW = $clog2(POSIT_WIDTH) + 1;

    logic                          s1_en, s2_en, s3_en;
    logic                          v1_q, v2_q, v3_q;

    logic                          s1_sign_q, s1_zero_q, s1_nar_q;
    logic [N-2:0]                  s1_body_q;
    logic [N-2:0]                  body_d;
    logic                          zero_d, nar_d;

    logic                          s2_sign_q, s2_zero_q, s2_nar_q;
    logic [N-2:0]                  s2_body_q;
    logic signed [SCALE_WIDTH-1:0] s2_k_q;
    logic [CW-1:0]                 s2_shamt_q;
    logic [CW-1:0]                 run_d;
    logic                          run_stop_d;
    logic signed [SCALE_WIDTH-1:0] k_d;
    logic [CW-1:0]                 shamt_d;

    logic [N-2:0]                  shifted_d;
    logic [SCALE_WIDTH-1:0]        exp_d;
    logic [SCALE_WIDTH-1:0]        scale_d;
    logic [FRACTION_WIDTH-1:0]     frac_d;

    // Ready chain: a stage may load when empty or when its successor takes its word.
    always_comb begin
        s3_en = ~v3_q | out_ready;
        s2_en = ~v2_q | s3_en;
        s1_en = ~v1_q | s2_en;
    end

    assign in_ready  = s1_en;
    assign out_valid = v3_q;

    // S1 combinational: specials and the low N-1 bits of the magnitude (two's complement
    // negation of the low bits depends only on the low bits).
    always_comb begin
        zero_d = (posit_word_i == {N{1'b0}});
        nar_d  = (posit_word_i == {1'b1, {(N-1){1'b0}}});
        if (posit_word_i[N-1]) begin
            body_d = ~posit_word_i[N-2:0] + {{(N-2){1'b0}}, 1'b1};
        end else begin
            body_d = posit_word_i[N-2:0];
        end
    end

    // S1 registers: valid bit, sign, special flags and magnitude body.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q      <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_nar_q  <= 1'b0;
            s1_body_q <= {(N-1){1'b0}};
        end else if (s1_en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                s1_sign_q <= posit_word_i[N-1];
                s1_zero_q <= zero_d;
                s1_nar_q  <= nar_d;
                s1_body_q <= body_d;
            end
        end
    end

    // S2 combinational: regime run length from the body MSB, regime value k and shift.
    always_comb begin
        run_d      = {CW{1'b0}};
        run_stop_d = 1'b0;
        for (int i = N - 2; i >= 0; i--) begin
            if (!run_stop_d && (s1_body_q[i] == s1_body_q[N-2])) begin
                run_d = run_d + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                run_stop_d = 1'b1;
            end
        end
        if (s1_body_q[N-2]) begin
            k_d = SCALE_WIDTH'(run_d) - {{(SCALE_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            k_d = -SCALE_WIDTH'(run_d);
        end
        shamt_d = run_d + {{(CW-1){1'b0}}, 1'b1};
    end

    // S2 registers: carry flags and body forward with k and the regime shift amount.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q       <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_body_q  <= {(N-1){1'b0}};
            s2_k_q     <= {SCALE_WIDTH{1'b0}};
            s2_shamt_q <= {CW{1'b0}};
        end else if (s2_en) begin
            v2_q <= v1_q;
            if (v1_q) begin
                s2_sign_q  <= s1_sign_q;
                s2_zero_q  <= s1_zero_q;
                s2_nar_q   <= s1_nar_q;
                s2_body_q  <= s1_body_q;
                s2_k_q     <= k_d;
                s2_shamt_q <= shamt_d;
            end
        end
    end

    // S3 combinational: dropping regime and terminator leaves e then fraction at the top;
    // a shift of N clears everything, which covers a regime that fills the word.
    always_comb begin
        shifted_d = s2_body_q << s2_shamt_q;
        exp_d     = SCALE_WIDTH'(shifted_d >> (N - 1 - POSIT_ES));
        scale_d   = (s2_k_q <<< POSIT_ES) + exp_d;
        frac_d    = shifted_d[N-2-POSIT_ES -: FRACTION_WIDTH];
    end

    // S3 registers drive the outputs; specials force the numeric fields to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            v3_q       <= 1'b0;
            sign_o     <= 1'b0;
            scale_o    <= {SCALE_WIDTH{1'b0}};
            fraction_o <= {FRACTION_WIDTH{1'b0}};
            zero_o     <= 1'b0;
            NaR_o      <= 1'b0;
        end else if (s3_en) begin
            v3_q <= v2_q;
            if (v2_q) begin
                zero_o <= s2_zero_q;
                NaR_o  <= s2_nar_q;
                if (s2_zero_q || s2_nar_q) begin
                    sign_o     <= 1'b0;
                    scale_o    <= {SCALE_WIDTH{1'b0}};
                    fraction_o <= {FRACTION_WIDTH{1'b0}};
                end else begin
                    sign_o     <= s2_sign_q;
                    scale_o    <= scale_d;
                    fraction_o <= frac_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_decode_pipe.sv
// Self-checking bench for posit_decode_pipe (N=32, ES=2): directed vectors, latency,
// throughput, backpressure, reset flush and a randomized scoreboard run.
module tb_posit_decode_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] posit_word_i;
    logic        out_valid;
    logic        out_ready;
    logic        sign_o;
    logic [7:0]  scale_o;
    logic [26:0] fraction_o;
    logic        zero_o;
    logic        NaR_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [37:0] exp_q[$];
    logic [31:0] src_q[$];

    posit_decode_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .posit_word_i (posit_word_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sign_o       (sign_o),
        .scale_o      (scale_o),
        .fraction_o   (fraction_o),
        .zero_o       (zero_o),
        .NaR_o        (NaR_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] out_fields();
        return {sign_o, scale_o, fraction_o, zero_o, NaR_o};
    endfunction

    // Reference decoder: walks the bit string of the magnitude position by position.
    function automatic logic [37:0] ref_dec(input logic [31:0] w);
        logic        s, r, z, n;
        logic [31:0] a;
        logic [26:0] fr;
        int          m, i, k, p, e, scale, idx;
        s = 1'b0; z = 1'b0; n = 1'b0; fr = '0; scale = 0;
        if (w == 32'h0) begin
            z = 1'b1;
        end else if (w == 32'h8000_0000) begin
            n = 1'b1;
        end else begin
            s = w[31];
            a = s ? (~w + 32'd1) : w;
            r = a[30];
            m = 0;
            i = 30;
            while (i >= 0 && a[i] == r) begin
                m++;
                i--;
            end
            k = r ? m - 1 : -m;
            p = 30 - m - 1;
            e = 0;
            for (int j = 0; j < 2; j++) begin
                e = e * 2 + (((p - j) >= 0) ? int'(a[p-j]) : 0);
            end
            for (int j = 0; j < 27; j++) begin
                idx = p - 2 - j;
                fr[26-j] = (idx >= 0) ? a[idx] : 1'b0;
            end
            scale = k * 4 + e;
        end
        return {s, scale[7:0], fr, z, n};
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(15))
            0:       w = 32'h0000_0000;
            1:       w = 32'h8000_0000;
            2:       w = 32'h7FFF_FFFF;
            3:       w = 32'h0000_0001;
            4:       w = 32'h8000_0001;
            5:       w = $urandom >> $urandom_range(31);
            6:       w = ~($urandom >> $urandom_range(31));
            default: w = $urandom;
        endcase
        return w;
    endfunction

    // One word through an otherwise empty pipe, compared with hand-derived fields.
    task automatic dir_word(input string tag, input logic [31:0] w, input logic s,
                            input logic [7:0] sc, input logic [26:0] fr,
                            input logic z, input logic n);
        int cnt;
        in_valid     = 1'b1;
        posit_word_i = w;
        out_ready    = 1'b1;
        #1;
        check_eq({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 1;
        while (!out_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_eq({tag, "_latency"}, cnt, 3);
        check_eq({tag, "_fields"}, out_fields(), {s, sc, fr, z, n});
        @(posedge clk); #1;
        check_eq({tag, "_emitted_once"}, out_valid, 0);
    endtask

    // mode 0: random valid/ready and words; 1: streaming from src_q; 2: backpressure window.
    task automatic run(input int mode, input int n_words, input int max_cycles);
        int          sent, first_c, last_c;
        bit          prev_stall;
        logic [37:0] held, cur;
        logic [31:0] word;
        sent = 0; first_c = -1; last_c = -1; prev_stall = 0; held = '0;
        for (int c = 0; c < max_cycles; c++) begin
            if (sent >= n_words && exp_q.size() == 0) break;
            case (mode)
                0: begin
                    in_valid  = (sent < n_words) && ($urandom_range(3) != 0);
                    out_ready = ($urandom_range(3) != 0);
                end
                1: begin
                    in_valid  = (sent < n_words);
                    out_ready = 1'b1;
                end
                default: begin
                    in_valid  = (sent < n_words);
                    out_ready = !(c >= 3 && c <= 10);
                end
            endcase
            word = (mode == 0) ? rand_word() : ((sent < src_q.size()) ? src_q[sent] : 32'h0);
            posit_word_i = word;
            #1;
            cur = out_fields();
            if (prev_stall) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_hold", cur, held);
            end
            if (mode == 2 && c >= 3 && c <= 10) check_eq("bp_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_out", out_valid, 0);
                end else begin
                    check_eq("data", cur, exp_q.pop_front());
                end
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            prev_stall = out_valid && !out_ready;
            held       = cur;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_dec(word));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("all_sent", sent, n_words);
        check_eq("drained", exp_q.size(), 0);
        if (mode == 1) check_eq("throughput", last_c - first_c, n_words - 1);
        exp_q.delete();
        src_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b1;
        posit_word_i = 32'h4000_0000;
        out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_fields", out_fields(), 38'h0);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        check_eq("rst_ignored_valid", out_valid, 0);

        dir_word("one",      32'h4000_0000, 1'b0, 8'd0,   27'h0,       1'b0, 1'b0);
        dir_word("e1",       32'h4800_0000, 1'b0, 8'd1,   27'h0,       1'b0, 1'b0);
        dir_word("frac",     32'h4400_0000, 1'b0, 8'd0,   27'h400_0000, 1'b0, 1'b0);
        dir_word("neg_one",  32'hC000_0000, 1'b1, 8'd0,   27'h0,       1'b0, 1'b0);
        dir_word("maxpos",   32'h7FFF_FFFF, 1'b0, 8'd120, 27'h0,       1'b0, 1'b0);
        dir_word("minpos",   32'h0000_0001, 1'b0, 8'h88,  27'h0,       1'b0, 1'b0);
        dir_word("neg_max",  32'h8000_0001, 1'b1, 8'd120, 27'h0,       1'b0, 1'b0);
        dir_word("zero",     32'h0000_0000, 1'b0, 8'd0,   27'h0,       1'b1, 1'b0);
        dir_word("nar",      32'h8000_0000, 1'b0, 8'd0,   27'h0,       1'b0, 1'b1);

        src_q = '{32'h4000_0000, 32'h4800_0000, 32'h4400_0000, 32'hC000_0000};
        run(1, 4, 40);

        src_q = '{32'h4000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h4400_0000};
        run(2, 5, 60);

        // Three words in flight under stall, then reset must discard them.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid     = 1'b1;
            posit_word_i = 32'h4800_0000 + i;
            @(posedge clk); #1;
        end
        check_eq("flush_full", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("flush_out_valid", out_valid, 0);
        check_eq("flush_fields", out_fields(), 38'h0);
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq("flush_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_eq("flush_no_stale", out_valid, 0);
        end

        run(0, 10000, 40000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
